// File: rtl/space_wire_time_code_manager.sv
// SpaceWire time-code manager: validates received time-codes as time slave,
// or generates periodic / requested time-codes for the transmitter as time master.
module space_wire_time_code_manager #(
  parameter int TIME_WIDTH   = 6,
  parameter int PERIOD_WIDTH = 16,
  parameter int ERR_WIDTH    = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_master,
  input  logic [PERIOD_WIDTH-1:0] i_period,
  input  logic                    i_tick_req,
  input  logic [1:0]              i_flags,
  input  logic                    i_got_time_code,
  input  logic [TIME_WIDTH+1:0]   i_rx_time_code,
  input  logic                    i_tx_ack,
  input  logic                    i_clear_errors,
  output logic                    o_tx_req,
  output logic [TIME_WIDTH+1:0]   o_tx_time_code,
  output logic [TIME_WIDTH-1:0]   o_time_out,
  output logic [1:0]              o_control_flags_out,
  output logic                    o_tick_out,
  output logic                    o_locked,
  output logic                    o_seq_error,
  output logic                    o_timeout,
  output logic                    o_overrun,
  output logic [ERR_WIDTH-1:0]    o_error_count
);

  localparam int CODE_W = TIME_WIDTH + 2;

  logic [PERIOD_WIDTH-1:0] period_cnt_q;
  logic                    timeout_armed_q;
  logic                    master_q;

  logic [TIME_WIDTH-1:0]   expected_time;
  logic [TIME_WIDTH-1:0]   rx_time;
  logic [1:0]              rx_flags;
  logic                    period_on;
  logic                    period_hit;
  logic                    mode_change;
  logic                    tx_acked;
  logic                    master_event;
  logic                    rx_in_seq;
  logic                    seq_err_now;

  // The local time and the time a slave expects next are always one apart,
  // so "expected" is derived rather than stored.
  assign expected_time = o_time_out + 1'b1;
  assign rx_time       = i_rx_time_code[TIME_WIDTH-1:0];
  assign rx_flags      = i_rx_time_code[CODE_W-1:TIME_WIDTH];

  // ">=" rather than "==" so a period shortened on the fly cannot strand the counter.
  assign period_on   = (i_period != '0);
  assign period_hit  = period_on && (period_cnt_q >= (i_period - 1'b1));
  assign mode_change = (i_master != master_q);

  // Transmit handshake: o_tx_req/o_tx_time_code stay stable while o_tx_req=1;
  // a transfer completes on any edge where o_tx_req=1 and i_tx_ack=1.
  assign tx_acked     = o_tx_req && i_tx_ack;
  assign master_event = i_master && !mode_change && (period_hit || i_tick_req);

  assign rx_in_seq   = (rx_time == expected_time);
  assign seq_err_now = !i_master && !mode_change && i_got_time_code && !rx_in_seq;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_time_out          <= '0;
      o_control_flags_out <= '0;
      o_tx_req            <= 1'b0;
      o_tx_time_code      <= '0;
      o_tick_out          <= 1'b0;
      o_locked            <= 1'b0;
      o_seq_error         <= 1'b0;
      o_timeout           <= 1'b0;
      o_overrun           <= 1'b0;
      period_cnt_q        <= '0;
      timeout_armed_q     <= 1'b1;
      master_q            <= i_master;
    end else begin
      o_tick_out  <= 1'b0;
      o_seq_error <= 1'b0;
      o_timeout   <= 1'b0;
      o_overrun   <= 1'b0;
      master_q    <= i_master;

      if (mode_change) begin
        // Switching roles discards any pending code but keeps the time base.
        period_cnt_q    <= '0;
        o_tx_req        <= 1'b0;
        o_tx_time_code  <= '0;
        o_locked        <= 1'b0;
        timeout_armed_q <= 1'b1;
      end else if (i_master) begin
        o_locked <= 1'b0;

        if (master_event || !period_on) begin
          period_cnt_q <= '0;
        end else begin
          period_cnt_q <= period_cnt_q + 1'b1;
        end

        if (master_event) begin
          if (!o_tx_req || tx_acked) begin
            o_time_out          <= expected_time;
            o_control_flags_out <= i_flags;
            o_tx_time_code      <= {i_flags, expected_time};
            o_tx_req            <= 1'b1;
            o_tick_out          <= 1'b1;
          end else begin
            o_overrun <= 1'b1;
          end
        end else if (tx_acked) begin
          o_tx_req <= 1'b0;
        end
      end else begin
        o_tx_req <= 1'b0;

        if (i_got_time_code) begin
          // Received time and flags are always adopted, in sequence or not.
          o_time_out          <= rx_time;
          o_control_flags_out <= rx_flags;
          period_cnt_q        <= '0;
          timeout_armed_q     <= 1'b1;
          if (rx_in_seq) begin
            o_tick_out <= 1'b1;
            o_locked   <= 1'b1;
          end else begin
            o_seq_error <= 1'b1;
            o_locked    <= 1'b0;
          end
        end else if (period_on) begin
          if (period_hit) begin
            period_cnt_q <= '0;
            if (timeout_armed_q) begin
              o_timeout       <= 1'b1;
              o_locked        <= 1'b0;
              timeout_armed_q <= 1'b0;
            end
          end else begin
            period_cnt_q <= period_cnt_q + 1'b1;
          end
        end else begin
          period_cnt_q <= '0;
        end
      end
    end
  end

  // A clear coinciding with a sequence error leaves that error counted.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_error_count <= '0;
    end else if (i_clear_errors) begin
      o_error_count <= seq_err_now ? ERR_WIDTH'(1) : '0;
    end else if (seq_err_now && !(&o_error_count)) begin
      o_error_count <= o_error_count + 1'b1;
    end
  end

endmodule
